// File: rtl/wb_common_pkg.sv
// rtl/wb_common_pkg.sv - Wishbone B3 cycle-type/burst-type constants and address helpers
package wb_common;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Next beat address; a wrap only disturbs the bits inside the wrap window.
  function automatic logic [63:0] wb_next_adr(input logic [63:0] adr, input logic [2:0] cti,
                                              input logic [1:0] bte, input int dw);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'(dw / 8);
    case (bte)
      BTE_WRAP4:  mask = (step << 2) - 64'd1;
      BTE_WRAP8:  mask = (step << 3) - 64'd1;
      BTE_WRAP16: mask = (step << 4) - 64'd1;
      default:    mask = '1;
    endcase
    if (cti == CTI_CLASSIC) return adr;
    return (adr & ~mask) | ((adr + step) & mask);
  endfunction

  function automatic logic wb_is_last(input logic [2:0] cti);
    return (cti == CTI_EOB) || (cti == CTI_CLASSIC);
  endfunction

  function automatic logic [1:0] wb_bte_for(input logic wrap, input int beats);
    if (!wrap) return BTE_LINEAR;
    case (beats)
      4:       return BTE_WRAP4;
      8:       return BTE_WRAP8;
      16:      return BTE_WRAP16;
      default: return BTE_LINEAR;
    endcase
  endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// rtl/wb_burst_master_if.sv - Wishbone B3 master-side bus bundle
interface wb_burst_master_if #(
  parameter int dw = 32,
  parameter int aw = 32
) ();
  logic [aw-1:0]   wb_adr_o;
  logic [dw-1:0]   wb_dat_o;
  logic [dw/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic [1:0]      wb_bte_o;
  logic [2:0]      wb_cti_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic [dw-1:0]   wb_dat_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
    input  wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
    output wb_ack_i, wb_err_i, wb_dat_i
  );
endinterface

// File: rtl/wb_burst_master_adr_gen.sv
// rtl/wb_burst_master_adr_gen.sv - beat cycle type and next-beat address for the burst master
module wb_burst_adr_gen
  import wb_common::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int burst_len = 4
) (
  input  logic [aw-1:0] adr_i,
  input  logic [4:0]    cnt_i,
  input  logic          wrap_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] next_adr_o,
  output logic [2:0]    cti_o
);
  localparam int Step      = dw / 8;
  localparam int LineBytes = burst_len * Step;

  always_comb begin
    if (burst_len == 1)                        cti_o = CTI_CLASSIC;
    else if (cnt_i == 5'(burst_len - 1))       cti_o = CTI_EOB;
    else                                       cti_o = CTI_INC;

    next_adr_o = aw'(wb_next_adr(64'(adr_i), cti_o, bte_i, dw));
    // Wrapping lines with no BTE encoding (2 beats) still wrap inside the line.
    if (wrap_i && (bte_i == BTE_LINEAR))
      next_adr_o = (adr_i & ~aw'(LineBytes - 1)) | ((adr_i + aw'(Step)) & aw'(LineBytes - 1));
  end
endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - single-request Wishbone B3 burst master for cache line refill/writeback
module wb_burst_master
  import wb_common::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int burst_len = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [aw-1:0]   req_adr_i,
  input  logic            req_wrap_i,
  input  logic            wd_valid_i,
  output logic            wd_ready_o,
  input  logic [dw-1:0]   wd_dat_i,
  input  logic [dw/8-1:0] wd_sel_i,
  output logic            rd_valid_o,
  input  logic            rd_ready_i,
  output logic [dw-1:0]   rd_dat_o,
  output logic            rd_last_o,
  output logic            done_o,
  output logic            err_o,
  wb_burst_master_if.master wb
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          we_q, we_d;
  logic          wrap_q, wrap_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [1:0]    bte_q, bte_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [aw-1:0] next_adr;
  logic [2:0]    cti;
  logic          in_burst, beat_ack, is_last;

  wb_burst_adr_gen #(.dw(dw), .aw(aw), .burst_len(burst_len)) u_adr_gen (
    .adr_i     (adr_q),
    .cnt_i     (cnt_q),
    .wrap_i    (wrap_q),
    .bte_i     (bte_q),
    .next_adr_o(next_adr),
    .cti_o     (cti)
  );

  assign in_burst = (state_q == S_BURST);
  // An error on the same cycle as an ack wins: that beat is neither counted nor handed over.
  assign beat_ack = in_burst && wb.wb_ack_i && !wb.wb_err_i;
  assign is_last  = (cnt_q == 5'(burst_len - 1));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wrap_d  = wrap_q;
    adr_d   = adr_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_BURST;
          we_d    = req_we_i;
          wrap_d  = req_wrap_i;
          adr_d   = req_adr_i;
          bte_d   = wb_bte_for(req_wrap_i, burst_len);
          cnt_d   = '0;
          cyc_d   = 1'b1;
        end
      end
      S_BURST: begin
        if (wb.wb_err_i) begin
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (wb.wb_ack_i) begin
          cnt_d = cnt_q + 5'd1;
          adr_d = next_adr;
          if (is_last) begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      wrap_q  <= 1'b0;
      adr_q   <= '0;
      bte_q   <= BTE_LINEAR;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wrap_q  <= wrap_d;
      adr_q   <= adr_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = !in_burst;
  assign wd_ready_o  = beat_ack && we_q;
  assign rd_valid_o  = beat_ack && !we_q;
  assign rd_dat_o    = wb.wb_dat_i;
  assign rd_last_o   = rd_valid_o && is_last;
  assign done_o      = done_q;
  assign err_o       = err_q;

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = in_burst && (we_q ? wd_valid_i : rd_ready_i);
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_bte_o = bte_q;
  assign wb.wb_cti_o = in_burst ? cti : CTI_CLASSIC;
  assign wb.wb_dat_o = wd_dat_i;
  assign wb.wb_sel_o = we_q ? wd_sel_i : '1;
endmodule
